// File: rtl/ahb_arbiter_nm.sv
// N-master AHB bus arbiter: fixed-priority or round-robin selection with locked
// sequences, a per-owner hold limit, burst protection and address/data-phase master indices.
module ahb_arbiter_nm #(
  parameter int NUM_M    = 4,
  parameter int RR_MODE  = 1,
  parameter int DEF_M    = 0,
  parameter int MAX_HOLD = 8,
  localparam int MW      = $clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] hbusreq,
  input  logic [NUM_M-1:0] hlock,
  input  logic [1:0]       htrans,
  input  logic             hready,
  output logic [NUM_M-1:0] hgrant,
  output logic [MW-1:0]    hmaster,
  output logic [MW-1:0]    hmaster_d,
  output logic             hmastlock
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [1:0] ST_PARK = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [1:0]       HTRANS_SEQ = 2'b11;
  localparam logic [MW-1:0]    DEF_IDX    = MW'(DEF_M);
  localparam logic [NUM_M-1:0] DEF_GRANT  = NUM_M'(1) << DEF_M;
  localparam logic [HW-1:0]    HOLD_MAX   = HW'(MAX_HOLD);

  logic [1:0]       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [MW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [MW-1:0]    hmaster_q;
  logic [MW-1:0]    hmaster_dph_q;
  logic             hmastlock_q;

  logic [MW-1:0]    owner;
  logic [NUM_M-1:0] others;
  logic [NUM_M-1:0] cand;
  logic             burst;
  logic             beat;
  logic             expire;
  logic             rearb;
  logic             win_vld;
  logic [MW-1:0]    win_idx;
  logic [MW-1:0]    pos;

  function automatic logic [NUM_M-1:0] to_onehot(input logic [MW-1:0] idx);
    logic [NUM_M-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [MW-1:0] to_index(input logic [NUM_M-1:0] oh);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (oh[i]) idx = idx | MW'(i);
    end
    return idx;
  endfunction

  // BUSY and SEQ both have htrans[0] set; NONSEQ and SEQ both have htrans[1] set.
  assign owner  = to_index(grant_q);
  assign others = hbusreq & ~grant_q;
  assign burst  = htrans[0];
  assign beat   = htrans[1];
  assign expire = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others);
  assign cand   = (state_q == ST_OWN) ? others : hbusreq;

  // Scan from the farthest candidate down so the closest hit overwrites last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      if (RR_MODE != 0) pos = MW'((int'(rr_ptr_q) + k) % NUM_M);
      else              pos = MW'(k - 1);
      if (cand[pos]) begin
        win_vld = 1'b1;
        win_idx = pos;
      end
    end
  end

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    rearb    = 1'b0;

    case (state_q)
      ST_PARK: rearb = (|hbusreq) && !burst;
      ST_OWN: begin
        if (hlock[owner] && hbusreq[owner]) state_d = ST_LOCK;
        else if (!burst && (!hbusreq[owner] || expire)) rearb = 1'b1;
      end
      ST_LOCK: begin
        if (!hlock[owner] && (htrans != HTRANS_SEQ)) state_d = ST_OWN;
      end
      default: state_d = ST_PARK;
    endcase

    if (rearb) begin
      if (win_vld) begin
        state_d = ST_OWN;
        grant_d = to_onehot(win_idx);
      end else begin
        state_d = ST_PARK;
        grant_d = DEF_GRANT;
      end
    end

    if (grant_d != grant_q) begin
      hold_d = '0;
      if (win_vld) rr_ptr_d = win_idx;
    end else if (beat && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PARK;
      grant_q       <= DEF_GRANT;
      rr_ptr_q      <= DEF_IDX;
      hold_q        <= '0;
      hmaster_q     <= DEF_IDX;
      hmaster_dph_q <= DEF_IDX;
      hmastlock_q   <= 1'b0;
    end else if (hready) begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_q        <= hold_d;
      hmaster_q     <= owner;
      hmaster_dph_q <= hmaster_q;
      hmastlock_q   <= hlock[owner];
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = hmaster_q;
  assign hmaster_d = hmaster_dph_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_nm.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter driven by shared
// directed and random stimulus, compared every cycle against a behavioural model.
module tb_ahb_arbiter_nm;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic       clk;
  logic       rst;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic       cmp_en;

  logic [3:0] rr_hgrant, fp_hgrant;
  logic [1:0] rr_hmaster, fp_hmaster, rr_hmaster_d, fp_hmaster_d;
  logic       rr_hmastlock, fp_hmastlock;

  int checks   = 0;
  int failures = 0;

  ahb_arbiter_nm #(.NUM_M(4), .RR_MODE(1), .DEF_M(0), .MAX_HOLD(1)) u_rr (
    .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans), .hready(hready),
    .hgrant(rr_hgrant), .hmaster(rr_hmaster), .hmaster_d(rr_hmaster_d), .hmastlock(rr_hmastlock)
  );

  ahb_arbiter_nm #(.NUM_M(4), .RR_MODE(0), .DEF_M(0), .MAX_HOLD(2)) u_fp (
    .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans), .hready(hready),
    .hgrant(fp_hgrant), .hmaster(fp_hmaster), .hmaster_d(fp_hmaster_d), .hmastlock(fp_hmastlock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural view of one arbiter: who owns the bus, whether it is parked or locked,
  // beats used by the owner, last winner, and the two pipelined master indices.
  typedef struct {
    bit parked;
    bit locked;
    int own;
    int hold;
    int rr;
    int hm;
    int hmd;
    int hml;
  } mdl_t;

  function automatic mdl_t mdl_reset(input int def_m);
    mdl_t s;
    s.parked = 1'b1; s.locked = 1'b0; s.own = def_m; s.hold = 0;
    s.rr = def_m; s.hm = def_m; s.hmd = def_m; s.hml = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic [3:0] req, input logic [3:0] lk,
                                    input logic [1:0] tr, input bit rr_mode, input int max_hold,
                                    input int def_m);
    mdl_t n;
    bit   in_burst, is_beat, arb;
    logic [3:0] pool, rest;
    int   win, j;
    n        = s;
    in_burst = (tr == BUSY) || (tr == SEQ);
    is_beat  = (tr == NONSEQ) || (tr == SEQ);
    arb      = 1'b0;
    pool     = 4'b0;
    win      = -1;
    rest     = req;
    rest[s.own] = 1'b0;
    n.hm  = s.own;
    n.hmd = s.hm;
    n.hml = int'(lk[s.own]);
    if (s.parked) begin
      if (req != 4'b0 && !in_burst) begin arb = 1'b1; pool = req; end
    end else if (s.locked) begin
      if (!lk[s.own] && tr != SEQ) n.locked = 1'b0;
    end else if (lk[s.own] && req[s.own]) begin
      n.locked = 1'b1;
    end else if (!in_burst &&
                 (!req[s.own] || (max_hold > 0 && s.hold == max_hold && rest != 4'b0))) begin
      arb = 1'b1; pool = rest;
    end
    if (arb) begin
      for (int k = 1; k <= 4; k++) begin
        j = rr_mode ? (s.rr + k) % 4 : k - 1;
        if (pool[j] && win < 0) win = j;
      end
      if (win < 0) begin n.parked = 1'b1; n.own = def_m; end
      else         begin n.parked = 1'b0; n.own = win; end
    end
    if (n.own != s.own) begin
      n.hold = 0;
      if (win >= 0) n.rr = win;
    end else if (is_beat && s.hold < max_hold) begin
      n.hold = s.hold + 1;
    end
    return n;
  endfunction

  mdl_t m_rr, m_fp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr <= mdl_reset(0);
      m_fp <= mdl_reset(0);
    end else if (hready) begin
      m_rr <= mdl_step(m_rr, hbusreq, hlock, htrans, 1'b1, 1, 0);
      m_fp <= mdl_step(m_fp, hbusreq, hlock, htrans, 1'b0, 2, 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("rr_hgrant",    32'(rr_hgrant),    32'(1) << m_rr.own);
      check("rr_hmaster",   32'(rr_hmaster),   32'(m_rr.hm));
      check("rr_hmaster_d", 32'(rr_hmaster_d), 32'(m_rr.hmd));
      check("rr_hmastlock", 32'(rr_hmastlock), 32'(m_rr.hml));
      check("rr_onehot",    32'($onehot(rr_hgrant)), 32'd1);
      check("fp_hgrant",    32'(fp_hgrant),    32'(1) << m_fp.own);
      check("fp_hmaster",   32'(fp_hmaster),   32'(m_fp.hm));
      check("fp_hmaster_d", 32'(fp_hmaster_d), 32'(m_fp.hmd));
      check("fp_hmastlock", 32'(fp_hmastlock), 32'(m_fp.hml));
      check("fp_onehot",    32'($onehot(fp_hgrant)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    hbusreq = 4'b0; hlock = 4'b0; htrans = IDLE; hready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_grants(input string name, input logic [3:0] exp);
    check({name, "_rr"}, 32'(rr_hgrant), 32'(exp));
    check({name, "_fp"}, 32'(fp_hgrant), 32'(exp));
  endtask

  int r;

  initial begin
    cmp_en = 1'b0;
    hbusreq = 4'b0; hlock = 4'b0; htrans = IDLE; hready = 1'b1;
    rst = 1'b1;
    #3;
    check_grants("reset_grant", 4'b0001);
    check("reset_hmaster", 32'(rr_hmaster), 32'd0);
    check("reset_hmaster_d", 32'(fp_hmaster_d), 32'd0);
    check("reset_hmastlock", 32'(rr_hmastlock | fp_hmastlock), 32'd0);
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (5) tick();
    check_grants("idle_grant", 4'b0001);
    check("idle_hmaster", 32'(fp_hmaster), 32'd0);

    // Round-robin rotation with a one-beat hold limit.
    hbusreq = 4'b1111; htrans = NONSEQ;
    tick(); check("rot_e1", 32'(rr_hgrant), 32'h2);
    tick();
    tick(); check("rot_e3", 32'(rr_hgrant), 32'h4);
    tick(); check("rot_hmaster", 32'(rr_hmaster), 32'd2);
    check("rot_hmaster_d", 32'(rr_hmaster_d), 32'd1);
    tick(); check("rot_e5", 32'(rr_hgrant), 32'h8);
    tick();
    tick(); check("rot_e7", 32'(rr_hgrant), 32'h1);

    // SEQ burst holds the grant on M2 until IDLE.
    do_reset();
    hbusreq = 4'b0100; tick();
    check_grants("burst_own", 4'b0100);
    htrans = NONSEQ; tick();
    hbusreq = 4'b0101; htrans = SEQ;
    repeat (3) tick();
    check_grants("burst_hold", 4'b0100);
    htrans = IDLE; tick();
    check_grants("burst_end", 4'b0001);

    // Locked M1 ignores the hold limit until hlock drops at an IDLE.
    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010; tick();
    check_grants("lock_own", 4'b0010);
    hbusreq = 4'b0011; htrans = NONSEQ;
    repeat (6) tick();
    check_grants("lock_hold", 4'b0010);
    check("lock_hmastlock", 32'(fp_hmastlock & rr_hmastlock), 32'd1);
    hlock = 4'b0; htrans = IDLE; tick();
    check_grants("unlock_e1", 4'b0010);
    tick();
    check_grants("unlock_e2", 4'b0001);
    check("unlock_hmastlock", 32'(fp_hmastlock | rr_hmastlock), 32'd0);

    // hready low freezes everything.
    do_reset();
    hready = 1'b0;
    hbusreq = 4'b0100; tick();
    hbusreq = 4'b1000; tick();
    hbusreq = 4'b0100; tick();
    check_grants("stall_grant", 4'b0001);
    check("stall_hmaster", 32'(rr_hmaster | fp_hmaster), 32'd0);
    hready = 1'b1; tick();
    check_grants("stall_release", 4'b0100);

    // Asynchronous reset in the middle of an M3 burst.
    do_reset();
    hbusreq = 4'b1000; tick();
    check_grants("m3_own", 4'b1000);
    htrans = NONSEQ; tick();
    htrans = SEQ; tick();
    check("m3_hmaster", 32'(fp_hmaster), 32'd3);
    #1 rst = 1'b1;
    #1;
    check_grants("async_grant", 4'b0001);
    check("async_hmaster", 32'(rr_hmaster | fp_hmaster), 32'd0);
    check("async_hmaster_d", 32'(rr_hmaster_d | fp_hmaster_d), 32'd0);
    check("async_hmastlock", 32'(rr_hmastlock | fp_hmastlock), 32'd0);
    tick();
    rst = 1'b0;
    hbusreq = 4'b0; htrans = IDLE;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      hready = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0)  hbusreq[b] = ~hbusreq[b];
        if ($urandom_range(0, 15) == 0) hlock[b]   = ~hlock[b];
      end
      r = int'($urandom_range(0, 99));
      htrans = (r < 25) ? IDLE : (r < 35) ? BUSY : (r < 70) ? NONSEQ : SEQ;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
